// File: rtl/fpa_pkg.sv
// rtl/fpa_pkg.sv - shared single-precision field widths, states, limits and flag layout
package fpa_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;
    localparam int ACC_W = 56;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_ROUND,
        ST_OUT
    } state_e;

    localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    localparam int FLAG_INVALID  = 2;
    localparam int FLAG_OVERFLOW = 1;
    localparam int FLAG_INEXACT  = 0;

    function automatic logic [2:0] mk_flags(input logic invalid, input logic overflow,
                                            input logic inexact);
        logic [2:0] f;
        f                = '0;
        f[FLAG_INVALID]  = invalid;
        f[FLAG_OVERFLOW] = overflow;
        f[FLAG_INEXACT]  = inexact;
        return f;
    endfunction

endpackage

// File: rtl/fpa_round_rne.sv
// rtl/fpa_round_rne.sv - round-to-nearest-even of a fixed-point magnitude
module fpa_round_rne (
    input  logic [32:0] acc_hi_i,
    input  logic        sticky_i,
    output logic [31:0] mag_o,
    output logic        inexact_o
);

    logic lsb;
    logic guard;
    logic up;

    // acc_hi_i[32:1] is the integer part, acc_hi_i[0] the first fraction bit
    always_comb begin
        lsb       = acc_hi_i[1];
        guard     = acc_hi_i[0];
        up        = guard & (lsb | sticky_i);
        mag_o     = acc_hi_i[32:1] + {31'b0, up};
        inexact_o = guard | sticky_i;
    end

endmodule

// File: rtl/fp_to_int_seq.sv
// rtl/fp_to_int_seq.sv - serial float32 to int32 converter with RNE rounding and saturation
module fp_to_int_seq
    import fpa_pkg::*;
#(
    parameter int STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_x,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_int,
    output logic [2:0]  out_flags
);

    localparam logic [4:0] STEP_K = 5'(STEP);

    state_e             state_q;
    logic [ACC_W-1:0]   acc_q;
    logic [4:0]         cnt_q;
    logic               sign_q;
    logic               out_valid_q;
    logic [31:0]        out_int_q;
    logic [2:0]         out_flags_q;

    logic               x_s;
    logic [EXP_W-1:0]   x_e;
    logic [MAN_W-1:0]   x_m;
    logic [4:0]         shift_k;
    logic [4:0]         cnt_d;
    logic [ACC_W-1:0]   acc_d;
    logic [31:0]        mag;
    logic               rnd_inexact;

    always_comb begin
        x_s     = in_x[31];
        x_e     = in_x[30:23];
        x_m     = in_x[22:0];
        shift_k = (cnt_q < STEP_K) ? cnt_q : STEP_K;
        acc_d   = acc_q << shift_k;
        cnt_d   = cnt_q - shift_k;
    end

    fpa_round_rne u_round (
        .acc_hi_i  (acc_q[55:23]),
        .sticky_i  (|acc_q[22:0]),
        .mag_o     (mag),
        .inexact_o (rnd_inexact)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            sign_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_int_q   <= '0;
            out_flags_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        sign_q <= x_s;
                        if (x_e == 8'd255) begin
                            out_int_q   <= (x_m != '0) ? INT_MIN : (x_s ? INT_MIN : INT_MAX);
                            out_flags_q <= (x_m != '0) ? mk_flags(1'b1, 1'b0, 1'b0)
                                                       : mk_flags(1'b0, 1'b1, 1'b0);
                            out_valid_q <= 1'b1;
                            state_q     <= ST_OUT;
                        end else if (x_e >= 8'd158) begin
                            // exactly -2^31 is the one representable value in this range
                            if (in_x == 32'hCF00_0000) begin
                                out_int_q   <= INT_MIN;
                                out_flags_q <= '0;
                            end else begin
                                out_int_q   <= x_s ? INT_MIN : INT_MAX;
                                out_flags_q <= mk_flags(1'b0, 1'b1, 1'b0);
                            end
                            out_valid_q <= 1'b1;
                            state_q     <= ST_OUT;
                        end else if (x_e <= 8'd125) begin
                            out_int_q   <= '0;
                            out_flags_q <= mk_flags(1'b0, 1'b0, (x_e != '0) || (x_m != '0));
                            out_valid_q <= 1'b1;
                            state_q     <= ST_OUT;
                        end else if (x_e == 8'd126) begin
                            acc_q   <= {32'b0, 1'b1, x_m};
                            state_q <= ST_ROUND;
                        end else begin
                            acc_q   <= {31'b0, 1'b1, x_m, 1'b0};
                            cnt_q   <= 5'(x_e - 8'(BIAS));
                            state_q <= (x_e == 8'(BIAS)) ? ST_ROUND : ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_d;
                    if (cnt_d == '0) begin
                        state_q <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    out_int_q   <= sign_q ? (32'd0 - mag) : mag;
                    out_flags_q <= mk_flags(1'b0, 1'b0, rnd_inexact);
                    out_valid_q <= 1'b1;
                    state_q     <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_int   = out_int_q;
    assign out_flags = out_flags_q;

endmodule

// File: tb/tb_fp_to_int_seq.sv
// tb/tb_fp_to_int_seq.sv - directed vector bench for fp_to_int_seq at STEP 1 and STEP 8
module tb_fp_to_int_seq;

    logic        clk;
    logic        rst;
    logic [1:0]  in_valid_a;
    logic [1:0]  in_ready_a;
    logic [31:0] in_x_a [2];
    logic [1:0]  out_valid_a;
    logic [1:0]  out_ready_a;
    logic [31:0] out_int_a [2];
    logic [2:0]  out_flags_a [2];

    int checks;
    int errors;

    typedef struct {
        logic [31:0] x;
        logic [31:0] exp_int;
        logic [2:0]  exp_flags;
        int          exp_lat;
        string       name;
    } vec_t;

    vec_t vecs[$];

    fp_to_int_seq #(.STEP(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_a[0]),
        .in_ready  (in_ready_a[0]),
        .in_x      (in_x_a[0]),
        .out_valid (out_valid_a[0]),
        .out_ready (out_ready_a[0]),
        .out_int   (out_int_a[0]),
        .out_flags (out_flags_a[0])
    );

    fp_to_int_seq #(.STEP(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_a[1]),
        .in_ready  (in_ready_a[1]),
        .in_x      (in_x_a[1]),
        .out_valid (out_valid_a[1]),
        .out_ready (out_ready_a[1]),
        .out_int   (out_int_a[1]),
        .out_flags (out_flags_a[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [31:0] x, input logic [31:0] ei,
                                 input logic [2:0] ef, input int lat, input string name);
        vec_t v;
        v.x = x; v.exp_int = ei; v.exp_flags = ef; v.exp_lat = lat; v.name = name;
        return v;
    endfunction

    // Sends one float with out_ready held high; latency counts the acceptance edge as cycle 0.
    task automatic run_one(input int d, input vec_t v);
        int lat;
        chk({v.name, " ready"}, 32'(in_ready_a[d]), 32'd1);
        in_x_a[d]     = v.x;
        in_valid_a[d] = 1'b1;
        @(posedge clk); #1;
        in_valid_a[d] = 1'b0;
        chk({v.name, " busy"}, 32'(in_ready_a[d]), 32'd0);
        lat = 1;
        while (!out_valid_a[d] && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({v.name, " lat"}, 32'(lat), 32'(v.exp_lat));
        chk({v.name, " int"}, out_int_a[d], v.exp_int);
        chk({v.name, " flags"}, 32'(out_flags_a[d]), 32'(v.exp_flags));
        @(posedge clk); #1;
        chk({v.name, " idle"}, {30'b0, in_ready_a[d], out_valid_a[d]}, 32'd2);
    endtask

    initial begin
        int lat;
        int seen;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        in_valid_a = '0;
        out_ready_a = 2'b11;
        in_x_a[0] = '0;
        in_x_a[1] = '0;

        vecs.push_back(mkv(32'h3F80_0000, 32'h0000_0001, 3'b000,  2, "one"));
        vecs.push_back(mkv(32'h4020_0000, 32'h0000_0002, 3'b001,  3, "2.5"));
        vecs.push_back(mkv(32'hC060_0000, 32'hFFFF_FFFC, 3'b001,  3, "-3.5"));
        vecs.push_back(mkv(32'h5015_02F9, 32'h7FFF_FFFF, 3'b010,  1, "1e10"));
        vecs.push_back(mkv(32'hD015_02F9, 32'h8000_0000, 3'b010,  1, "-1e10"));
        vecs.push_back(mkv(32'hCF00_0000, 32'h8000_0000, 3'b000,  1, "-2^31"));
        vecs.push_back(mkv(32'hCF00_0001, 32'h8000_0000, 3'b010,  1, "below-2^31"));
        vecs.push_back(mkv(32'h4F00_0000, 32'h7FFF_FFFF, 3'b010,  1, "+2^31"));
        vecs.push_back(mkv(32'h7FC0_0000, 32'h8000_0000, 3'b100,  1, "nan"));
        vecs.push_back(mkv(32'h7F80_0000, 32'h7FFF_FFFF, 3'b010,  1, "+inf"));
        vecs.push_back(mkv(32'hFF80_0000, 32'h8000_0000, 3'b010,  1, "-inf"));
        vecs.push_back(mkv(32'h0000_0000, 32'h0000_0000, 3'b000,  1, "zero"));
        vecs.push_back(mkv(32'h0000_0001, 32'h0000_0000, 3'b001,  1, "denorm"));
        vecs.push_back(mkv(32'h3E80_0000, 32'h0000_0000, 3'b001,  1, "0.25"));
        vecs.push_back(mkv(32'h3F00_0000, 32'h0000_0000, 3'b001,  2, "0.5"));
        vecs.push_back(mkv(32'hBF00_0000, 32'h0000_0000, 3'b001,  2, "-0.5"));
        vecs.push_back(mkv(32'h3F40_0000, 32'h0000_0001, 3'b001,  2, "0.75"));
        vecs.push_back(mkv(32'h3FC0_0000, 32'h0000_0002, 3'b001,  2, "1.5"));
        vecs.push_back(mkv(32'hBF80_0000, 32'hFFFF_FFFF, 3'b000,  2, "-1"));
        vecs.push_back(mkv(32'h42C8_0000, 32'h0000_0064, 3'b000,  8, "100"));
        vecs.push_back(mkv(32'h4B00_0001, 32'h0080_0001, 3'b000, 25, "2^23+1"));
        vecs.push_back(mkv(32'h4AFF_FFFF, 32'h0080_0000, 3'b001, 24, "tie-odd"));
        vecs.push_back(mkv(32'h4EFF_FFFF, 32'h7FFF_FF80, 3'b000, 32, "max-e157"));

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst in_ready", 32'(in_ready_a[0]), 32'd1);
        chk("rst out_valid", 32'(out_valid_a[0]), 32'd0);
        chk("rst out_int", out_int_a[0], 32'd0);
        chk("rst out_flags", 32'(out_flags_a[0]), 32'd0);

        foreach (vecs[i]) run_one(0, vecs[i]);

        run_one(1, mkv(32'h4EFF_FFFF, 32'h7FFF_FF80, 3'b000, 6, "s8 max-e157"));
        run_one(1, mkv(32'h4020_0000, 32'h0000_0002, 3'b001, 3, "s8 2.5"));
        run_one(1, mkv(32'h42C8_0000, 32'h0000_0064, 3'b000, 3, "s8 100"));

        // Backpressure: result held, second request ignored until the handshake
        out_ready_a[0] = 1'b0;
        in_x_a[0] = 32'h4020_0000;
        in_valid_a[0] = 1'b1;
        @(posedge clk); #1;
        in_x_a[0] = 32'h3F80_0000;
        lat = 1;
        while (!out_valid_a[0] && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp lat", 32'(lat), 32'd3);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("bp int", out_int_a[0], 32'h0000_0002);
            chk("bp flags", 32'(out_flags_a[0]), 32'd1);
            chk("bp hold", {30'b0, in_ready_a[0], out_valid_a[0]}, 32'd1);
        end
        out_ready_a[0] = 1'b1;
        @(posedge clk); #1;
        chk("bp release", {30'b0, in_ready_a[0], out_valid_a[0]}, 32'd2);
        @(posedge clk); #1;
        in_valid_a[0] = 1'b0;
        chk("bp second busy", 32'(in_ready_a[0]), 32'd0);
        lat = 1;
        while (!out_valid_a[0] && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp second lat", 32'(lat), 32'd2);
        chk("bp second int", out_int_a[0], 32'h0000_0001);
        @(posedge clk); #1;

        // Reset in the middle of a long shift drops the transaction
        in_x_a[0] = 32'h4EFF_FFFF;
        in_valid_a[0] = 1'b1;
        @(posedge clk); #1;
        in_valid_a[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid-rst in_ready", 32'(in_ready_a[0]), 32'd1);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (out_valid_a[0]) seen++;
        end
        chk("mid-rst no output", 32'(seen), 32'd0);
        run_one(0, mkv(32'h3F80_0000, 32'h0000_0001, 3'b000, 2, "post-rst one"));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_to_int_seq.md
# fp_to_int_seq

Sequential IEEE-754 single-precision to signed 32-bit integer converter for the floating-point datapath, the decode counterpart to the single-precision adder's pack and normalize stage. It accepts one packed float per transaction over a valid/ready handshake and aligns the significand with a serial shifter, 1..STEP bits per cycle. It rounds to nearest-even (the same rule the adder uses), saturates out-of-range values, and returns the integer with exception flags over a second valid/ready handshake.

## Interface
- STEP, default 1: maximum left-shift bits applied per SHIFT cycle; legal values are 1, 2, 4, 8.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous and active-high.
- in_valid  in  1  in_x is valid.
- in_ready  out  1  converter idle; equals (state == IDLE).
- in_x  in  32  packed float: {sign, exp[7:0], mantissa[22:0]}.
- out_valid  out  1  out_int and out_flags are valid.
- out_ready  in  1  consumer accepts the result.
- out_int  out  32  two's-complement result.
- out_flags  out  3  {invalid, overflow, inexact}.

## Operation
- States: IDLE, SHIFT, ROUND, OUT.
- IDLE: a transfer happens when in_valid && in_ready. On a transfer, decode s, e, m; sig = {1, m}; E = e − 127.
- exp == 255, m != 0 (NaN): out_int = 0x8000_0000, flags = 3'b100. Go to OUT.
- exp == 255, m == 0 (±inf): saturate to 0x7FFF_FFFF (+) or 0x8000_0000 (−), flags = 3'b010. Go to OUT.
- e ≥ 158:
  - in_x == 0xCF00_0000 (exactly −2^31): out_int = 0x8000_0000, flags = 0.
  - Otherwise: saturate by sign, flags = 3'b010.
  - Go to OUT.
- e == 0 (zero or denormal): treated as zero, as in the adder. out_int = 0; inexact = (m != 0). Go to OUT.
- 1 ≤ e ≤ 125 (|x| < 0.5): out_int = 0, inexact = 1. Go to OUT.
- e == 126: acc[55:0] = {32'b0, sig}, i.e. sig right-shifted by 1 from the nominal position. Go to ROUND.
- 127 ≤ e ≤ 157: acc = sig placed at acc[24:1]; cnt = E (0..30).
  - cnt == 0: go to ROUND.
  - Otherwise go to SHIFT.
- acc fixed point: integer part acc[55:24], fraction acc[23:0].
- SHIFT: each cycle, k = min(cnt, STEP); acc <<= k; cnt −= k. Leave for ROUND when cnt reaches 0.
- ROUND:
  - up = acc[23] && (acc[24] || |acc[22:0]).
  - mag = acc[55:24] + up. mag < 2^31 always holds in this range, so no overflow is possible.
  - out_int = s ? −mag : mag. A rounded zero gives 0, never a negative zero pattern.
  - inexact = |acc[23:0]; invalid = overflow = 0.
  - Go to OUT.
- OUT: out_valid = 1. out_int and out_flags stay stable until out_ready. On out_valid && out_ready, go to IDLE.
- No overlap: at most one transaction in flight. in_ready is low from the acceptance edge until the cycle after the output handshake.
- rst, including mid-SHIFT/ROUND/OUT: the in-flight transaction is dropped with no output. Registers return to reset values the next edge.

## Timing
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, out_int = 0, out_flags = 0, acc = 0, cnt = 0.
- Count the acceptance edge as cycle 0.
- Special cases (NaN, inf, saturate, zero, e ≤ 125): out_valid first high in cycle 1.
- e == 126, or E == 0: out_valid high in cycle 2.
- E ≥ 1: out_valid high in cycle ceil(E/STEP) + 2.
- Worst case with STEP = 1 (e = 157): 32 cycles to out_valid.
- A consumer holding out_ready high gives 1 cycle in OUT. in_ready returns high the following cycle.
- in_valid while busy is ignored. The producer must hold in_x until in_ready.

## Structure
- Shared package fpa_pkg holds:
  - field widths (EXP_W = 8, MAN_W = 23);
  - BIAS = 127;
  - the state enum;
  - INT_MAX = 0x7FFF_FFFF and INT_MIN = 0x8000_0000;
  - the flag bit indices.
- One natural sub-module, fpa_round_rne: combinational, takes acc[55:23] and the sticky bit, returns mag and inexact. The adder will later reuse it.
- Everything else lives in one FSM module.

## Test plan
- 0x3F80_0000 (1.0) with STEP = 1, out_ready held high → out_valid in cycle 2, out_int = 1, flags = 000.
- 0x4020_0000 (2.5) → out_int = 2 (tie to even), flags = 001, out_valid in cycle 3. 0xC060_0000 (−3.5) → 0xFFFF_FFFC, flags = 001.
- 0x501502F9 (1e10) → 0x7FFF_FFFF, flags = 010, cycle 1. 0xCF00_0000 → 0x8000_0000, flags = 000. 0x7FC0_0000 → 0x8000_0000, flags = 100.
- 0x4EFF_FFFF (e = 157, STEP = 1 then STEP = 8) → 0x7FFF_FF80, flags = 000. out_valid in cycle 32 and cycle 6 respectively.
- Backpressure: out_ready low for 5 cycles in OUT → out_int and out_flags stable, in_ready low, a second in_valid ignored. The second float is accepted only after the handshake.
- rst pulsed mid-SHIFT of 0x4EFF_FFFF → no out_valid. Next cycle in_ready = 1. A following 0x3F80_0000 converts correctly.
